intr_ctrl_mv: RTL and testbench
===============================

// Module: intr_ctrl_mv
// PURPOSE
//   Multi-vector successor to the single-line e1000 interrupt controller. Latches interrupt
//   causes into ICR and masks them with IMS/IMC. Routes each cause to one of N_VEC vectors
//   through a per-cause map table. Each vector has its own ITR throttle and a req/ack
//   handshake to the MSI/MSI-X message engine. It sits between the cause sources
//   (tx/rx/phy/mdio) and the PCIe message path.
// PARAMETERS
//   CLK_PERIOD_NS  8    clk_i period in ns
//   TICK_NS        256  throttle granularity in ns; TICK_CYC = TICK_NS/CLK_PERIOD_NS (>=1)
//   SRC_W          32   cause vector width (ICR bits)
//   N_VEC          4    number of interrupt vectors (>=1); VI_W = max(1,$clog2(N_VEC))
//   ITR_W          16   throttle interval counter width
// PORTS
//   clk_i      in   1          clock
//   rst_i      in   1          async active-high reset
//   src_req_i  in   SRC_W      cause pulses/levels from function blocks
//   ICR        in   SRC_W      write data, write-1-to-clear
//   ICR_set    in   1          ICR write strobe
//   ICR_get    in   1          ICR read strobe (read-to-clear)
//   ICR_fb_o   out  SRC_W      current cause state (read data)
//   ICS        in   SRC_W      write data, write-1-to-set causes
//   ICS_set    in   1          ICS write strobe
//   IMS        in   SRC_W      write data, mask set
//   IMS_set    in   1          IMS write strobe
//   IMC        in   SRC_W      write data, mask clear
//   IMC_set    in   1          IMC write strobe
//   IMS_fb_o   out  SRC_W      current mask (read data)
//   itr_wr     in   1          per-vector interval write strobe
//   itr_idx    in   VI_W       vector index for itr_wr
//   itr_val    in   ITR_W      interval in ticks
//   ivar_wr    in   1          cause-to-vector map write strobe
//   ivar_idx   in   $clog2(SRC_W)  cause bit index
//   ivar_vec   in   VI_W       target vector
//   vec_req_o  out  N_VEC      per-vector message request, held until ack
//   vec_ack_i  in   N_VEC      per-vector message accepted (1-cycle pulse)
//   intr_o     out  1          OR of vec_req_o (legacy INTx level)
// BEHAVIOUR
//   Reset: state, mask, map (all causes->vector 0), itr (0), tick counter all 0.
//     All FSMs IDLE. All outputs 0.
//   Cause state: next = ICR_get ? 0 : ICR_set ? state&~ICR : ICS_set ? state|ICS : state.
//     state <= next | src_req_i. A source asserting in the same cycle as a clear/read wins.
//   Mask: IMS_set -> mask|=IMS, else IMC_set -> mask&=~IMC. IMS wins if both strobes are set.
//   Map/ITR writes: an index >= N_VEC (or ivar_idx >= SRC_W) is ignored. Writes take effect
//     next cycle. A running throttle count is not reloaded by an itr_wr.
//   pend[v] = |(state & mask & {cause bits mapped to v}), combinational.
//   Tick: free-running counter 0..TICK_CYC-1; tick=1 for one cycle when count==TICK_CYC-1.
//   Per-vector FSM (registered):
//     IDLE: pend[v] -> REQ.
//     REQ:  vec_req_o[v]=1. On vec_ack_i[v]: itr[v]==0 -> IDLE, else load cnt=itr[v] and go
//           to HOLD. If pend[v] is 0 and there is no ack -> IDLE (request withdrawn).
//           Ack and pend drop in the same cycle: ack wins.
//     HOLD: on tick, cnt-=1. When cnt==1 and tick occur together -> IDLE. Causes accumulate
//           in state meanwhile. Acks outside REQ are ignored.
//   Latency: src pulse sampled at edge t -> ICR bit at t+1 -> vec_req_o high after edge t+2.
//   Throttle gap from ack to re-request: between (itr-1)*TICK_CYC+1 and itr*TICK_CYC+1 cycles.
//   Vectors are fully independent. Simultaneous acks to several vectors are all honoured.
//   intr_o = |vec_req_o (registered FSM decode, no glitches).
//   rst_i mid-handshake: request drops asynchronously. The message engine discards it.
// TESTING
//   Pulse src bit 7 with mask 0x80 and map 7->v2 -> vec_req_o=4'b0100 two cycles later,
//     held until ack.
//   Set itr[2]=3 with TICK_CYC=32, ack, then re-raise the cause -> vec_req_o[2] stays low for
//     65..97 cycles after ack.
//   Clear the cause via ICR write while in REQ without ack -> req withdrawn next cycle,
//     FSM IDLE.
//   Raise src bit 0 in the same cycle as ICR_get -> ICR_fb_o bit 0 reads 1 next cycle.
//   Set IMS=IMC=0x4 in the same cycle -> mask bit 2 ends at 1. ivar_vec=N_VEC -> map unchanged.
//   Assert rst_i during HOLD -> all outputs 0 immediately. After release, a pending cause
//     re-requests with no throttle.

Source files
------------

// File: rtl/intr_ctrl_mv_if.sv
// Register-bus and message-handshake bundle for the multi-vector interrupt controller.
// The slave modport is the controller's view. The master modport is the view of the
// register host, the cause sources and the message engine.
interface intr_ctrl_mv_if #(
  parameter int SRC_W = 32,
  parameter int N_VEC = 4,
  parameter int ITR_W = 16
);
  localparam int VI_W  = (N_VEC > 1) ? $clog2(N_VEC) : 1;
  localparam int IDX_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;

  logic [SRC_W-1:0] src_req_i;
  logic [SRC_W-1:0] ICR;
  logic             ICR_set;
  logic             ICR_get;
  logic [SRC_W-1:0] ICR_fb_o;
  logic [SRC_W-1:0] ICS;
  logic             ICS_set;
  logic [SRC_W-1:0] IMS;
  logic             IMS_set;
  logic [SRC_W-1:0] IMC;
  logic             IMC_set;
  logic [SRC_W-1:0] IMS_fb_o;
  logic             itr_wr;
  logic [VI_W-1:0]  itr_idx;
  logic [ITR_W-1:0] itr_val;
  logic             ivar_wr;
  logic [IDX_W-1:0] ivar_idx;
  logic [VI_W-1:0]  ivar_vec;
  logic [N_VEC-1:0] vec_req_o;
  logic [N_VEC-1:0] vec_ack_i;
  logic             intr_o;

  modport slave (
    input  src_req_i, ICR, ICR_set, ICR_get, ICS, ICS_set,
    input  IMS, IMS_set, IMC, IMC_set,
    input  itr_wr, itr_idx, itr_val, ivar_wr, ivar_idx, ivar_vec, vec_ack_i,
    output ICR_fb_o, IMS_fb_o, vec_req_o, intr_o
  );

  modport master (
    output src_req_i, ICR, ICR_set, ICR_get, ICS, ICS_set,
    output IMS, IMS_set, IMC, IMC_set,
    output itr_wr, itr_idx, itr_val, ivar_wr, ivar_idx, ivar_vec, vec_ack_i,
    input  ICR_fb_o, IMS_fb_o, vec_req_o, intr_o
  );
endinterface

// File: rtl/intr_ctrl_mv.sv
// Multi-vector interrupt controller: latched causes (ICR/ICS), mask (IMS/IMC),
// cause-to-vector map, and a per-vector throttled req/ack handshake toward the
// MSI/MSI-X message engine. intr_o is the legacy INTx level.
module intr_ctrl_mv #(
  parameter int CLK_PERIOD_NS = 8,
  parameter int TICK_NS       = 256,
  parameter int SRC_W         = 32,
  parameter int N_VEC         = 4,
  parameter int ITR_W         = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  intr_ctrl_mv_if.slave bus
);
  localparam int TICK_RAW = TICK_NS / CLK_PERIOD_NS;
  localparam int TICK_CYC = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int TCK_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int VI_W     = (N_VEC > 1) ? $clog2(N_VEC) : 1;
  localparam int IDX_W    = (SRC_W > 1) ? $clog2(SRC_W) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [SRC_W-1:0] state_q, state_d;
  logic [SRC_W-1:0] mask_q, mask_d;
  logic [VI_W-1:0]  map_q [SRC_W];
  logic [VI_W-1:0]  map_d [SRC_W];
  logic [ITR_W-1:0] itr_q [N_VEC];
  logic [ITR_W-1:0] itr_d [N_VEC];
  logic [TCK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [N_VEC-1:0] pend;
  logic             vec_ok;
  wire  [N_VEC-1:0] req_w;

  // Cause latch and mask update; a live source always beats a same-cycle clear or read.
  always_comb begin
    if (bus.ICR_get)      state_d = '0;
    else if (bus.ICR_set) state_d = state_q & ~bus.ICR;
    else if (bus.ICS_set) state_d = state_q | bus.ICS;
    else                  state_d = state_q;
    state_d = state_d | bus.src_req_i;

    if (bus.IMS_set)      mask_d = mask_q | bus.IMS;
    else if (bus.IMC_set) mask_d = mask_q & ~bus.IMC;
    else                  mask_d = mask_q;
  end

  // Map and interval tables; out-of-range indices or vectors never match and are dropped.
  always_comb begin
    vec_ok = int'(bus.ivar_vec) < N_VEC;
    for (int b = 0; b < SRC_W; b++) begin
      map_d[b] = map_q[b];
      if (bus.ivar_wr && vec_ok && bus.ivar_idx == IDX_W'(b)) map_d[b] = bus.ivar_vec;
    end
    for (int v = 0; v < N_VEC; v++) begin
      itr_d[v] = itr_q[v];
      if (bus.itr_wr && bus.itr_idx == VI_W'(v)) itr_d[v] = bus.itr_val;
    end
  end

  // Free-running throttle tick, one cycle wide every TICK_CYC cycles.
  always_comb begin
    tick       = (tick_cnt_q == TCK_W'(TICK_CYC - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Pending per vector: any unmasked active cause mapped to that vector.
  always_comb begin
    pend = '0;
    for (int v = 0; v < N_VEC; v++) begin
      for (int b = 0; b < SRC_W; b++) begin
        if (state_q[b] && mask_q[b] && map_q[b] == VI_W'(v)) pend[v] = 1'b1;
      end
    end
  end

  // Shared register state, asynchronously cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= '0;
      mask_q     <= '0;
      tick_cnt_q <= '0;
      for (int b = 0; b < SRC_W; b++) map_q[b] <= '0;
      for (int v = 0; v < N_VEC; v++) itr_q[v] <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      tick_cnt_q <= tick_cnt_d;
      for (int b = 0; b < SRC_W; b++) map_q[b] <= map_d[b];
      for (int v = 0; v < N_VEC; v++) itr_q[v] <= itr_d[v];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_VEC; gi++) begin : g_vec
      logic [1:0]       fsm_q, fsm_d;
      logic [ITR_W-1:0] cnt_q, cnt_d;

      // Request/throttle sequencing; an ack in REQ beats a same-cycle withdrawal.
      always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        case (fsm_q)
          ST_IDLE: if (pend[gi]) fsm_d = ST_REQ;
          ST_REQ: begin
            if (bus.vec_ack_i[gi]) begin
              if (itr_q[gi] == '0) begin
                fsm_d = ST_IDLE;
              end else begin
                fsm_d = ST_HOLD;
                cnt_d = itr_q[gi];
              end
            end else if (!pend[gi]) begin
              fsm_d = ST_IDLE;
            end
          end
          ST_HOLD: begin
            if (tick) begin
              if (cnt_q <= ITR_W'(1)) fsm_d = ST_IDLE;
              else                    cnt_d = cnt_q - 1'b1;
            end
          end
          default: fsm_d = ST_IDLE;
        endcase
      end

      // Vector state, dropped asynchronously so an in-flight request disappears at once.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          fsm_q <= ST_IDLE;
          cnt_q <= '0;
        end else begin
          fsm_q <= fsm_d;
          cnt_q <= cnt_d;
        end
      end

      assign req_w[gi] = (fsm_q == ST_REQ);
    end
  endgenerate

  assign bus.vec_req_o = req_w;
  assign bus.intr_o    = |req_w;
  assign bus.ICR_fb_o  = state_q;
  assign bus.IMS_fb_o  = mask_q;
endmodule

// File: tb/tb_intr_ctrl_mv.sv
// Directed bench for intr_ctrl_mv: latency, hold/withdraw, clear/read races, mask
// priority, out-of-range map write, throttle gap, multi-ack and async reset.
// Three vectors so that an out-of-range vector number is representable.
module tb_intr_ctrl_mv;
  localparam int SRC_W = 32;
  localparam int N_VEC = 3;
  localparam int ITR_W = 16;

  logic clk_i;
  logic rst_i;
  int   n_cmp;
  int   n_err;
  int   n;

  intr_ctrl_mv_if #(.SRC_W(SRC_W), .N_VEC(N_VEC), .ITR_W(ITR_W)) ifc ();

  intr_ctrl_mv #(
    .CLK_PERIOD_NS(8), .TICK_NS(256), .SRC_W(SRC_W), .N_VEC(N_VEC), .ITR_W(ITR_W)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (ifc)
  );

  initial clk_i = 1'b0;
  always #4 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_strobes();
    ifc.ICR_set = 0; ifc.ICR_get = 0; ifc.ICS_set = 0;
    ifc.IMS_set = 0; ifc.IMC_set = 0; ifc.itr_wr = 0; ifc.ivar_wr = 0;
    ifc.vec_ack_i = '0; ifc.src_req_i = '0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    ifc.ICR = '0; ifc.ICS = '0; ifc.IMS = '0; ifc.IMC = '0;
    ifc.itr_idx = '0; ifc.itr_val = '0; ifc.ivar_idx = '0; ifc.ivar_vec = '0;
    clr_strobes();
    rst_i = 1'b1;
    repeat (3) step();
    chk("rst_req",  32'(ifc.vec_req_o), 32'h0);
    chk("rst_intr", 32'(ifc.intr_o), 32'h0);
    chk("rst_icr",  ifc.ICR_fb_o, 32'h0);
    chk("rst_ims",  ifc.IMS_fb_o, 32'h0);
    rst_i = 1'b0;
    step();

    // Mask bit 7, map cause 7 to vector 2, pulse source 7
    ifc.IMS = 32'h80; ifc.IMS_set = 1;
    ifc.ivar_wr = 1; ifc.ivar_idx = 5'd7; ifc.ivar_vec = 2'd2;
    step(); clr_strobes();
    chk("ims_80", ifc.IMS_fb_o, 32'h80);
    ifc.src_req_i = 32'h80;
    step(); clr_strobes();
    chk("lat_icr",  ifc.ICR_fb_o, 32'h80);
    chk("lat_req0", 32'(ifc.vec_req_o), 32'h0);
    step();
    chk("lat_req",  32'(ifc.vec_req_o), 32'h4);
    chk("lat_intr", 32'(ifc.intr_o), 32'h1);
    repeat (3) step();
    chk("req_held", 32'(ifc.vec_req_o), 32'h4);

    // Ack with itr 0: straight back to IDLE, cause still set so it re-requests
    ifc.vec_ack_i = 3'b100;
    step(); clr_strobes();
    chk("ack_idle", 32'(ifc.vec_req_o), 32'h0);
    step();
    chk("rereq", 32'(ifc.vec_req_o), 32'h4);

    // Clear the cause while in REQ: request withdrawn one cycle later
    ifc.ICR = 32'h80; ifc.ICR_set = 1;
    step(); clr_strobes();
    chk("icr_clr",   ifc.ICR_fb_o, 32'h0);
    chk("req_still", 32'(ifc.vec_req_o), 32'h4);
    step();
    chk("withdraw",  32'(ifc.vec_req_o), 32'h0);
    chk("intr_low",  32'(ifc.intr_o), 32'h0);

    // Read-to-clear racing a source
    ifc.ICS = 32'h2; ifc.ICS_set = 1;
    step(); clr_strobes();
    chk("ics_set", ifc.ICR_fb_o, 32'h2);
    ifc.ICR_get = 1; ifc.src_req_i = 32'h1;
    step(); clr_strobes();
    chk("get_race", ifc.ICR_fb_o, 32'h1);
    ifc.ICR_get = 1;
    step(); clr_strobes();
    chk("get_clr", ifc.ICR_fb_o, 32'h0);

    // IMS wins over IMC in the same cycle
    ifc.IMS = 32'h4; ifc.IMS_set = 1; ifc.IMC = 32'h4; ifc.IMC_set = 1;
    step(); clr_strobes();
    chk("ims_imc", ifc.IMS_fb_o, 32'h84);
    ifc.IMC = 32'h4; ifc.IMC_set = 1;
    step(); clr_strobes();
    chk("imc_only", ifc.IMS_fb_o, 32'h80);

    // Out-of-range vector number leaves cause 7 on vector 2
    ifc.ivar_wr = 1; ifc.ivar_idx = 5'd7; ifc.ivar_vec = 2'd3;
    step(); clr_strobes();
    ifc.ICS = 32'h80; ifc.ICS_set = 1;
    step(); clr_strobes();
    step();
    chk("map_oor", 32'(ifc.vec_req_o), 32'h4);

    // Throttle: itr[2]=3 ticks of 32 cycles; ack and clear in one cycle (ack wins)
    ifc.itr_wr = 1; ifc.itr_idx = 2'd2; ifc.itr_val = 16'd3;
    step(); clr_strobes();
    ifc.vec_ack_i = 3'b100; ifc.ICR = 32'h80; ifc.ICR_set = 1;
    step(); clr_strobes();
    chk("hold_entry", 32'(ifc.vec_req_o), 32'h0);
    ifc.src_req_i = 32'h80;
    step(); clr_strobes();
    n = 1;
    while (ifc.vec_req_o[2] == 1'b0 && n < 200) begin
      step();
      n++;
    end
    $display("throttle gap %0d cycles", n);
    chk("thr_min", 32'(n >= 65), 32'h1);
    chk("thr_max", 32'(n <= 97), 32'h1);

    // Simultaneous acks on all vectors
    ifc.ivar_wr = 1; ifc.ivar_idx = 5'd3; ifc.ivar_vec = 2'd1;
    ifc.IMS = 32'h18; ifc.IMS_set = 1;
    step(); clr_strobes();
    ifc.ICS = 32'h18; ifc.ICS_set = 1;
    step(); clr_strobes();
    step();
    chk("multi_req", 32'(ifc.vec_req_o), 32'h7);
    ifc.vec_ack_i = 3'b111; ifc.ICR = 32'h98; ifc.ICR_set = 1;
    step(); clr_strobes();
    chk("multi_ack", 32'(ifc.vec_req_o), 32'h0);
    step();
    chk("multi_idle", 32'(ifc.vec_req_o), 32'h0);

    // Vector 2 now holding; raise causes for v2 and v0, then reset mid-cycle
    ifc.ICS = 32'h90; ifc.ICS_set = 1;
    step(); clr_strobes();
    step();
    chk("pre_rst", 32'(ifc.vec_req_o), 32'h1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_async_req",  32'(ifc.vec_req_o), 32'h0);
    chk("rst_async_intr", 32'(ifc.intr_o), 32'h0);
    chk("rst_async_icr",  ifc.ICR_fb_o, 32'h0);
    chk("rst_async_ims",  ifc.IMS_fb_o, 32'h0);
    step();
    rst_i = 1'b0;
    step();

    // After reset the pending cause requests immediately, no leftover throttle
    ifc.IMS = 32'h80; ifc.IMS_set = 1;
    ifc.ivar_wr = 1; ifc.ivar_idx = 5'd7; ifc.ivar_vec = 2'd2;
    ifc.ICS = 32'h80; ifc.ICS_set = 1;
    step(); clr_strobes();
    step();
    chk("post_rst_req", 32'(ifc.vec_req_o), 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
